// File: rtl/text_terminal_ctrl_pkg.sv
// Shared definitions for the text terminal path: geometry defaults, ASCII codes, FSM states.
package text_pkg;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [6:0] CH_BLANK = 7'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CHAR,
    ST_WR_BS,
    ST_NEWLINE,
    ST_CLR_ROW,
    ST_CLR_ALL
  } term_state_t;

endpackage

// File: rtl/text_terminal_ctrl_if.sv
// Byte-source handshake, text-buffer write port and cursor signals of the terminal controller.
interface text_term_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic       busy;
  logic       write_enable;
  logic [6:0] write_x;
  logic [4:0] write_y;
  logic [6:0] write_data;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       clearing;

  modport master (
    input  char_valid, char_data, busy,
    output char_ready, write_enable, write_x, write_y, write_data,
           cursor_x, cursor_y, clearing
  );

  modport slave (
    output char_valid, char_data, busy,
    input  char_ready, write_enable, write_x, write_y, write_data,
           cursor_x, cursor_y, clearing
  );
endinterface

// File: rtl/text_terminal_ctrl_pacer.sv
// Turns a held write request into single strobes that respect busy and never run back to back.
module text_write_pacer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic       i_busy,
  input  logic [6:0] i_x,
  input  logic [4:0] i_y,
  input  logic [6:0] i_data,
  output logic       o_we,
  output logic [6:0] o_x,
  output logic [4:0] o_y,
  output logic [6:0] o_data,
  output logic       o_done
);

  logic r_strobe_d;

  // Gating with reset keeps the strobe low for every cycle reset is held.
  assign o_we   = i_req & ~i_busy & ~r_strobe_d & ~i_reset;
  assign o_x    = i_x;
  assign o_y    = i_y;
  assign o_data = i_data;
  assign o_done = r_strobe_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_strobe_d <= 1'b0;
    else         r_strobe_d <= o_we;
  end

endmodule

// File: rtl/text_terminal_ctrl.sv
// Byte-stream terminal: cursor tracking, control-code handling and row/screen clears into the text buffer.
//   state      | meaning
//   IDLE       | char_ready=1, decode an accepted byte
//   WR_CHAR    | write captured character at cursor, then advance
//   WR_BS      | blank the cell at the already decremented cursor
//   NEWLINE    | move to column 0 of the next row (bottom wraps to top)
//   CLR_ROW    | blank every column of the cursor row
//   CLR_ALL    | blank the whole screen row-major, then home the cursor
module text_terminal_ctrl
  import text_pkg::*;
#(
  parameter int         COLS  = TEXT_COLS,
  parameter int         ROWS  = TEXT_ROWS,
  parameter logic [6:0] BLANK = CH_BLANK
) (
  input logic       clk,
  input logic       reset,
  text_term_if.master term
);

  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  term_state_t r_state, w_state_nxt;
  logic [6:0]  r_cx, w_cx_nxt, r_ix, w_ix_nxt, r_char, w_char_nxt;
  logic [4:0]  r_cy, w_cy_nxt, r_iy, w_iy_nxt;
  logic        r_ready;
  logic        w_take, w_req, w_done;
  logic [6:0]  w_wx, w_wd;
  logic [4:0]  w_wy;

  assign w_take = term.char_valid & r_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLR_ALL;
      r_cx    <= '0;
      r_cy    <= '0;
      r_ix    <= '0;
      r_iy    <= '0;
      r_char  <= BLANK;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cx    <= w_cx_nxt;
      r_cy    <= w_cy_nxt;
      r_ix    <= w_ix_nxt;
      r_iy    <= w_iy_nxt;
      r_char  <= w_char_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_ix_nxt    = r_ix;
    w_iy_nxt    = r_iy;
    w_char_nxt  = r_char;
    w_req       = 1'b0;
    w_wx        = r_cx;
    w_wy        = r_cy;
    w_wd        = BLANK;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          if (term.char_data >= 8'h20 && term.char_data <= 8'h7E) begin
            w_char_nxt  = term.char_data[6:0];
            w_state_nxt = ST_WR_CHAR;
          end else if (term.char_data == CH_CR) begin
            w_cx_nxt = '0;
          end else if (term.char_data == CH_LF) begin
            w_state_nxt = ST_NEWLINE;
          end else if (term.char_data == CH_BS) begin
            if (r_cx != '0) begin
              w_cx_nxt    = r_cx - 7'd1;
              w_state_nxt = ST_WR_BS;
            end
          end else if (term.char_data == CH_FF) begin
            w_ix_nxt    = '0;
            w_iy_nxt    = '0;
            w_state_nxt = ST_CLR_ALL;
          end
        end
      end
      ST_WR_CHAR: begin
        w_req = 1'b1;
        w_wd  = r_char;
        if (w_done) begin
          if (r_cx < X_LAST) begin
            w_cx_nxt    = r_cx + 7'd1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_NEWLINE;
          end
        end
      end
      ST_WR_BS: begin
        w_req = 1'b1;
        if (w_done) w_state_nxt = ST_IDLE;
      end
      ST_NEWLINE: begin
        w_cx_nxt    = '0;
        w_cy_nxt    = (r_cy == Y_LAST) ? 5'd0 : r_cy + 5'd1;
        w_ix_nxt    = '0;
        w_state_nxt = ST_CLR_ROW;
      end
      ST_CLR_ROW: begin
        w_req = 1'b1;
        w_wx  = r_ix;
        if (w_done) begin
          if (r_ix == X_LAST) begin
            w_ix_nxt    = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ix_nxt = r_ix + 7'd1;
          end
        end
      end
      ST_CLR_ALL: begin
        w_req = 1'b1;
        w_wx  = r_ix;
        w_wy  = r_iy;
        if (w_done) begin
          if (r_ix == X_LAST) begin
            w_ix_nxt = '0;
            if (r_iy == Y_LAST) begin
              w_iy_nxt    = '0;
              w_cx_nxt    = '0;
              w_cy_nxt    = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_iy_nxt = r_iy + 5'd1;
            end
          end else begin
            w_ix_nxt = r_ix + 7'd1;
          end
        end
      end
      default: w_state_nxt = ST_CLR_ALL;
    endcase
  end

  text_write_pacer u_pacer (
    .i_clk   (clk),
    .i_reset (reset),
    .i_req   (w_req),
    .i_busy  (term.busy),
    .i_x     (w_wx),
    .i_y     (w_wy),
    .i_data  (w_wd),
    .o_we    (term.write_enable),
    .o_x     (term.write_x),
    .o_y     (term.write_y),
    .o_data  (term.write_data),
    .o_done  (w_done)
  );

  assign term.char_ready = r_ready;
  assign term.cursor_x   = r_cx;
  assign term.cursor_y   = r_cy;
  assign term.clearing   = (r_state == ST_CLR_ROW) || (r_state == ST_CLR_ALL);

endmodule

// File: tb/tb_text_terminal_ctrl.sv
// Directed and random byte streams against a cursor/screen-write model of the terminal controller.
module tb_text_terminal_ctrl;
  import text_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  text_term_if tif();

  text_terminal_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .term  (tif.master)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_strobes = 0;
  int          m_cx, m_cy;
  logic [18:0] exp_q[$];
  logic        prev_we = 1'b0;
  bit          busy_hold = 1'b0;
  bit          busy_rand = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic void push_wr(int x, int y, logic [6:0] d);
    exp_q.push_back({7'(x), 5'(y), d});
  endfunction

  function automatic void m_newline();
    m_cx = 0;
    m_cy = (m_cy + 1) % 30;
    for (int x = 0; x < 80; x++) push_wr(x, m_cy, 7'h20);
  endfunction

  function automatic void m_clear_all();
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++) push_wr(x, y, 7'h20);
    m_cx = 0;
    m_cy = 0;
  endfunction

  function automatic void m_apply(logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_cx, m_cy, b[6:0]);
      if (m_cx < 79) m_cx++;
      else m_newline();
    end else if (b == 8'h0D) m_cx = 0;
    else if (b == 8'h0A) m_newline();
    else if (b == 8'h08) begin
      if (m_cx > 0) begin
        m_cx--;
        push_wr(m_cx, m_cy, 7'h20);
      end
    end else if (b == 8'h0C) m_clear_all();
  endfunction

  always @(posedge clk) begin
    #2;
    if (busy_hold)      tif.busy = 1'b1;
    else if (busy_rand) tif.busy = ($urandom_range(0, 3) == 0);
    else                tif.busy = 1'b0;
  end

  always @(negedge clk) begin
    if (tif.write_enable === 1'b1) begin
      n_strobes++;
      check("we_vs_busy", tif.busy, 0);
      check("we_b2b", prev_we, 0);
      check("we_in_reset", reset, 0);
      if (exp_q.size() == 0) check("strobe_extra", tif.write_enable, 0);
      else check("strobe", {tif.write_x, tif.write_y, tif.write_data}, exp_q.pop_front());
    end
    prev_we = (tif.write_enable === 1'b1);
  end

  task automatic send_byte(logic [7:0] b);
    int cyc = 0;
    bit ok = 1'b0;
    tif.char_valid = 1'b1;
    tif.char_data  = b;
    while (cyc < 20000) begin
      @(negedge clk);
      if (tif.char_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    check("handshake_timeout", ok, 1);
    if (ok) m_apply(b);
    @(posedge clk);
    #2;
    tif.char_valid = 1'b0;
    tif.char_data  = 8'($urandom);
  endtask

  task automatic send_print(int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(32, 126)));
  endtask

  task automatic wait_idle(string tag);
    int cyc = 0;
    bit ok = 1'b0;
    while (cyc < 20000) begin
      @(negedge clk);
      if (tif.char_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    check({tag, "_timeout"}, ok, 1);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_cx"}, tif.cursor_x, m_cx);
    check({tag, "_cy"}, tif.cursor_y, m_cy);
    check({tag, "_clearing"}, tif.clearing, 0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n0;
    logic [7:0] b;
    tif.char_valid = 1'b0;
    tif.char_data  = 8'h00;
    m_cx = 0;
    m_cy = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", tif.write_enable, 0);
    check("rst_wx", tif.write_x, 0);
    check("rst_wy", tif.write_y, 0);
    check("rst_wd", tif.write_data, 7'h20);
    check("rst_cx", tif.cursor_x, 0);
    check("rst_cy", tif.cursor_y, 0);
    check("rst_ready", tif.char_ready, 0);
    check("rst_clearing", tif.clearing, 1);

    m_clear_all();
    n0 = n_strobes;
    @(posedge clk);
    #2 reset = 1'b0;
    wait_idle("por");
    check("por_count", n_strobes - n0, 2400);
    check("por_ready", tif.char_ready, 1);

    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle("ab");
    check("ab_cx", tif.cursor_x, 2);

    repeat (5) send_byte(CH_LF);
    send_print(79);
    wait_idle("to_79_5");
    check("at_79", tif.cursor_x, 79);
    n0 = n_strobes;
    send_byte(8'h5A);
    wait_idle("z_wrap");
    check("z_count", n_strobes - n0, 81);
    check("z_cx", tif.cursor_x, 0);
    check("z_cy", tif.cursor_y, 6);

    repeat (23) send_byte(CH_LF);
    send_print(3);
    wait_idle("to_3_29");
    send_byte(CH_LF);
    wait_idle("lf_wrap");
    check("lf_wrap_cy", tif.cursor_y, 0);
    send_print(5);
    wait_idle("to_5_0");
    n0 = n_strobes;
    send_byte(CH_CR);
    wait_idle("cr");
    check("cr_nowrite", n_strobes, n0);
    check("cr_cx", tif.cursor_x, 0);

    repeat (2) send_byte(CH_LF);
    send_print(4);
    wait_idle("to_4_2");
    n0 = n_strobes;
    send_byte(CH_BS);
    wait_idle("bs");
    check("bs_count", n_strobes - n0, 1);
    check("bs_cx", tif.cursor_x, 3);
    send_byte(CH_CR);
    n0 = n_strobes;
    send_byte(CH_BS);
    wait_idle("bs_col0");
    check("bs_col0_nowrite", n_strobes, n0);
    check("bs_col0_cy", tif.cursor_y, 2);

    send_byte(CH_LF);
    repeat (20) @(posedge clk);
    busy_hold = 1'b1;
    @(posedge clk);
    #3;
    n0 = n_strobes;
    repeat (50) @(posedge clk);
    #3;
    check("busy_hold_stall", n_strobes, n0);
    check("busy_hold_clearing", tif.clearing, 1);
    busy_hold = 1'b0;
    wait_idle("busy_resume");

    busy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
        6:       b = CH_CR;
        7:       b = CH_LF;
        8:       b = CH_BS;
        default: b = 8'($urandom_range(127, 255));
      endcase
      send_byte(b);
      if (i % 10 == 9) wait_idle("rand");
    end
    wait_idle("rand_end");

    send_byte(CH_FF);
    send_byte(8'h51);
    wait_idle("ff_q");
    check("ff_q_cx", tif.cursor_x, 1);
    check("ff_q_cy", tif.cursor_y, 0);

    send_byte(8'h2A);
    send_byte(CH_FF);
    repeat (300) @(posedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    m_clear_all();
    n0 = n_strobes;
    @(posedge clk);
    #2 reset = 1'b0;
    wait_idle("rst_mid");
    check("rst_mid_count", n_strobes - n0, 2400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_terminal_ctrl.md
Name: text_terminal_ctrl

Overview:
- Sequences the text buffer write port (write_enable/write_x/write_y/write_data, busy) from a byte stream such as a UART or keyboard decoder.
- Keeps a cursor and interprets printable ASCII plus CR, LF, BS and FF.
- Performs multi-write sequences (row clear, screen clear) while holding off the source.
- Sits between the character source and the text buffer of the VGA text display; its cursor outputs drive a cursor overlay.

Parameters:
- COLS, 80, columns per row; cursor x range 0..COLS-1.
- ROWS, 30, rows per screen; cursor y range 0..ROWS-1.
- BLANK, 7'h20, character code written when clearing.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- char_valid  in  1  source has a byte.
- char_data  in  8  ASCII byte.
- char_ready  out  1  controller accepts a byte this cycle.
- busy  in  1  text buffer busy; write_enable must be 0 while busy is 1.
- write_enable  out  1  one-cycle write strobe to the text buffer.
- write_x  out  7  write column.
- write_y  out  5  write row.
- write_data  out  7  write character.
- cursor_x  out  7  current cursor column.
- cursor_y  out  5  current cursor row.
- clearing  out  1  row or screen clear in progress.

Behaviour:
- Reset (sampled on posedge clk, overrides everything, aborts any sequence):
  - write_enable=0, write_x=0, write_y=0, write_data=BLANK, cursor=(0,0), char_ready=0, clearing=1.
  - Next state is CLR_ALL with clear index (0,0), so the screen is blanked at power-up.
- Handshake:
  - A byte transfers on a cycle with char_valid && char_ready.
  - char_ready=1 only in IDLE, as a registered output.
  - char_data is captured on transfer; the source may change it afterwards.
- Write rule:
  - write_enable is asserted only in a cycle where busy==0 and never in two consecutive cycles.
  - After a strobe, the FSM waits at least one cycle, then issues the next write on the first cycle with busy==0.
  - write_x, write_y and write_data are stable during the strobe cycle.
- States:
  - IDLE: char_ready=1.
    - Printable 0x20..0x7E -> WR_CHAR.
    - 0x0D (CR) -> cursor_x=0, stay in IDLE, no write.
    - 0x0A (LF) -> NEWLINE.
    - 0x08 (BS) -> if cursor_x>0: cursor_x-=1 and WR_BS; else no-op.
    - 0x0C (FF) -> CLR_ALL.
    - Any other byte is consumed and ignored.
  - WR_CHAR: write char_data[6:0] at the cursor, then advance.
    - cursor_x<COLS-1: cursor_x+1, go to IDLE.
    - Otherwise: NEWLINE.
  - WR_BS: write BLANK at the (already decremented) cursor, then IDLE.
  - NEWLINE: cursor_x=0; cursor_y=(cursor_y==ROWS-1)?0:cursor_y+1; then CLR_ROW on the new row.
  - CLR_ROW: COLS writes of BLANK at x=0..COLS-1 on cursor_y, then IDLE; clearing=1.
  - CLR_ALL: ROWS*COLS writes of BLANK in row-major order (x inner, y outer), then cursor=(0,0) and IDLE; clearing=1.
- Width and wrap rules:
  - The x counter compares against COLS-1; the y counter compares against ROWS-1.
  - No out-of-range address is ever driven.
  - There is no scrolling: the bottom row wraps to row 0, and that row is cleared first.
- Boundary cases:
  - A character at (COLS-1, ROWS-1) is written there, then row 0 is cleared and the cursor goes to (0,0).
  - BS at column 0 does not move up a row.
  - busy held high stalls any state indefinitely with write_enable=0; progress resumes when busy falls.
  - char_valid during a clear is ignored (char_ready=0) and the byte is not lost.

Decomposition:
- Shared package text_pkg holds:
  - ASCII constants CH_CR, CH_LF, CH_BS, CH_FF and CH_BLANK.
  - A state enum type, term_state_t.
  - Defaults TEXT_COLS=80 and TEXT_ROWS=30, shared with the buffer and the display controller.
- One sub-module, text_write_pacer:
  - Accepts a req/addr/data triple.
  - Emits the strobe under the busy and no-back-to-back rules.
  - Returns done one cycle after the strobe.
- The FSM, cursor and clear counters stay in text_terminal_ctrl.

Test Plan:
- Reset with busy=0 -> exactly 2400 strobes with data 0x20 covering every (x,y) once; then char_ready=1, cursor=(0,0), clearing=0.
- Send 'A'(0x41), 'B'(0x42) -> strobes (0,0,0x41), then (1,0,0x42); cursor=(2,0).
- Cursor at (79,5), send 'Z' -> strobe (79,5,0x5A), then 80 blank strobes on row 6; cursor=(0,6).
- Cursor at (3,29), send LF -> 80 blank strobes on row 0; cursor=(0,0). Then CR from (5,0) -> no strobe, cursor=(0,0).
- Cursor at (4,2), send BS -> strobe (3,2,0x20), cursor=(3,2). BS at (0,2) -> no strobe, cursor unchanged.
- Hold busy=1 for 50 cycles mid-CLR_ROW, and assert reset mid-CLR_ALL:
  - No strobe while busy=1; the sequence resumes without skipping an address.
  - After reset the clear restarts at (0,0) with the full 2400 strobes.
  - No strobe is ever adjacent to another or coincident with busy=1.
